// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types for the UART receive path: FSM states, word-length codes
// and the per-entry receive record stored in the FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRKWAIT
    } rx_state_t;

    localparam logic [1:0] WLEN_5 = 2'd0;
    localparam logic [1:0] WLEN_6 = 2'd1;
    localparam logic [1:0] WLEN_7 = 2'd2;
    localparam logic [1:0] WLEN_8 = 2'd3;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic [3:0] data_bits(input logic [1:0] wlen);
        case (wlen)
            WLEN_5:  return 4'd5;
            WLEN_6:  return 4'd6;
            WLEN_7:  return 4'd7;
            WLEN_8:  return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// Show-ahead receive FIFO of rx_entry_t. With UART_RX_FIFO_EN defined it holds
// DEPTH entries; otherwise it collapses to a single holding register.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
`ifdef UART_RX_FIFO_EN
    localparam int CW = $clog2(DEPTH + 1)
`else
    localparam int CW = 1
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rx_entry_t     entry_in,
    input  logic          pop,
    output rx_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic do_pop;
    logic do_push;

    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    rx_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; its contents are never visible
    // while empty, so clearing it would only cost flops and reset routing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= entry_in;
    end
`else
    rx_entry_t hold;
    logic      valid;

    assign empty = ~valid;
    assign full  = valid;
    assign count = valid;
    assign head  = valid ? hold : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold  <= '0;
            valid <= 1'b0;
        end else begin
            if (do_push) hold <= entry_in;
            if (do_push)     valid <= 1'b1;
            else if (do_pop) valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// UART receive core: synchroniser, mid-bit sampling FSM and receive FIFO.
// Define UART_RX_FIFO_EN for a DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int K_W   = 19,
`ifdef UART_RX_FIFO_EN
    localparam int CW = $clog2(DEPTH + 1)
`else
    localparam int CW = 1
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    input  logic [K_W-1:0] k,
    input  logic [1:0]     wlen,
    input  logic           pen,
    input  logic           even,
    input  logic           two_stop,
    input  logic           rd,
    input  logic           clr,
    output logic [7:0]     data,
    output logic           RXRDY,
    output logic           PERR,
    output logic           FERR,
    output logic           BRK,
    output logic           OVF,
    output logic [CW-1:0]  count
);

    logic           rx_meta, rxs, rxs_d;
    rx_state_t      state, state_next;
    logic [K_W-1:0] btc;
    logic           strobe, last_data, finish;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           par_q, stop_bad, all_zero;
    rx_entry_t      entry_next, entry_q, head;
    logic           push_q, fifo_full, fifo_empty, ovf_set;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_meta, rxs, rxs_d} <= 3'b111;
            state                 <= ST_IDLE;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
            state   <= state_next;
        end
    end

    // The start bit is checked at half a bit time; every later bit one full period on.
    assign strobe    = (state == ST_START) ? (btc == (k >> 1) - K_W'(1))
                                           : (btc == k - K_W'(1));
    assign last_data = ({1'b0, bit_idx} == data_bits(wlen) - 4'd1);

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next      = state;
        finish          = 1'b0;
        entry_next.data = shreg;
        entry_next.brk  = all_zero & ~rxs;
        entry_next.ferr = stop_bad | ~rxs;
        entry_next.perr = pen & (^shreg ^ par_q ^ ~even);
        case (state)
            ST_IDLE:   if (rxs_d & ~rxs) state_next = ST_START;
            ST_START:  if (strobe) state_next = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:   if (strobe && last_data) state_next = pen ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (strobe) state_next = ST_STOP1;
            ST_STOP1, ST_STOP2: begin
                if (strobe) begin
                    if (state == ST_STOP1 && two_stop) begin
                        state_next = ST_STOP2;
                    end else begin
                        finish     = 1'b1;
                        state_next = entry_next.brk ? ST_BRKWAIT : ST_IDLE;
                    end
                end
            end
            ST_BRKWAIT: if (rxs) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btc      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
            stop_bad <= 1'b0;
            all_zero <= 1'b1;
            push_q   <= 1'b0;
            entry_q  <= '0;
        end else begin
            push_q <= finish;
            if (finish) entry_q <= entry_next;

            if (state == ST_IDLE || state == ST_BRKWAIT || strobe) btc <= '0;
            else                                                    btc <= btc + K_W'(1);

            if (state == ST_IDLE) begin
                bit_idx  <= '0;
                shreg    <= '0;
                par_q    <= 1'b0;
                stop_bad <= 1'b0;
                all_zero <= 1'b1;
            end else if (strobe) begin
                case (state)
                    ST_DATA: begin
                        shreg[bit_idx] <= rxs;
                        bit_idx        <= bit_idx + 3'd1;
                        all_zero       <= all_zero & ~rxs;
                    end
                    ST_PARITY: begin
                        par_q    <= rxs;
                        all_zero <= all_zero & ~rxs;
                    end
                    ST_STOP1: begin
                        stop_bad <= ~rxs;
                        all_zero <= all_zero & ~rxs;
                    end
                    default: ;
                endcase
            end
        end
    end

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_q),
        .entry_in (entry_q),
        .pop      (rd),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    assign ovf_set = push_q & fifo_full & ~(rd & ~fifo_empty);

    always_ff @(posedge clk) begin
        if (rst)          OVF <= 1'b0;
        else if (ovf_set) OVF <= 1'b1;
        else if (clr)     OVF <= 1'b0;
    end

    assign data  = head.data;
    assign PERR  = head.perr;
    assign FERR  = head.ferr;
    assign BRK   = head.brk;
    assign RXRDY = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_core at k=16; expected depth follows UART_RX_FIFO_EN.
module tb_uart_rx_core;

`ifdef UART_RX_FIFO_EN
    localparam int EFF_DEPTH = 4;
    localparam int CW        = 3;
`else
    localparam int EFF_DEPTH = 1;
    localparam int CW        = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, rx, pen, even, two_stop, rd, clr;
    logic [18:0]   k;
    logic [1:0]    wlen;
    logic [7:0]    data;
    logic          RXRDY, PERR, FERR, BRK, OVF;
    logic [CW-1:0] count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_core #(.DEPTH(4), .K_W(19)) dut (
        .clk(clk), .rst(rst), .rx(rx), .k(k), .wlen(wlen), .pen(pen), .even(even),
        .two_stop(two_stop), .rd(rd), .clr(clr), .data(data), .RXRDY(RXRDY),
        .PERR(PERR), .FERR(FERR), .BRK(BRK), .OVF(OVF), .count(count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [7:0] d, input logic p,
                              input logic f, input logic b);
        check({tag, "_data"}, 32'(data), 32'(d));
        check({tag, "_perr"}, 32'(PERR), 32'(p));
        check({tag, "_ferr"}, 32'(FERR), 32'(f));
        check({tag, "_brk"},  32'(BRK),  32'(b));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy"},   32'(RXRDY), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_ovf"},   32'(OVF),   32'd0);
        check_head(tag, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pe,
                              input logic par, input logic s1, input logic s2,
                              input logic two);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (pe) drive_bit(par);
        drive_bit(s1);
        if (two) drive_bit(s2);
        rx = 1'b1;
    endtask

    task automatic pop();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        rst = 1'b1; rx = 1'b1; k = 19'd16; wlen = 2'd3; pen = 1'b0; even = 1'b0;
        two_stop = 1'b0; rd = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // 8N1 0xA5, then read it out and try a read on empty.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("a5_rdy", 32'(RXRDY), 32'd1);
        check("a5_count", 32'(count), 32'd1);
        check_head("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        pop();
        check("a5_pop_rdy", 32'(RXRDY), 32'd0);
        pop();
        check("empty_rd_count", 32'(count), 32'd0);

        // 7E1 0x41 (two ones) with parity bit 1 -> error; same bits under odd -> clean.
        wlen = 2'd2; pen = 1'b1; even = 1'b1;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_head("par_even", 8'h41, 1'b1, 1'b0, 1'b0);
        pop();
        even = 1'b0;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_head("par_odd", 8'h41, 1'b0, 1'b0, 1'b0);
        pop();

        // Short low pulse is a false start; next frame must still be clean.
        wlen = 2'd3; pen = 1'b0;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_rdy", 32'(RXRDY), 32'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("glitch_count", 32'(count), 32'd1);
        check_head("after_glitch", 8'h3C, 1'b0, 1'b0, 1'b0);
        pop();

        // Two stop bits with the second one low, then a long break.
        two_stop = 1'b1;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_head("stop2_bad", 8'h5A, 1'b0, 1'b1, 1'b0);
        pop();
        rx = 1'b0;
        repeat (384) @(negedge clk);
        check("brk_count", 32'(count), 32'd1);
        check_head("brk", 8'h00, 1'b0, 1'b1, 1'b1);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("brk_release_count", 32'(count), 32'd1);
        pop();
        two_stop = 1'b0;
        check("brk_pop_rdy", 32'(RXRDY), 32'd0);

        // Fill past capacity, clear OVF, then push and pop in the same cycle.
        for (int i = 1; i <= EFF_DEPTH + 1; i++) begin
            v = 8'h30 + 8'(i);
            send_frame(v, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        repeat (2) @(negedge clk);
        check("ovf_count", 32'(count), 32'(EFF_DEPTH));
        check("ovf_set", 32'(OVF), 32'd1);
        check("ovf_head", 32'(data), 32'h31);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ovf_clr", 32'(OVF), 32'd0);
        // Final stop strobe lands 155 edges after the start edge; push follows.
        fork
            send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            begin
                repeat (155) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("pushpop_count", 32'(count), 32'(EFF_DEPTH));
        check("pushpop_ovf", 32'(OVF), 32'd0);
        for (int j = 2; j <= EFF_DEPTH; j++) begin
            v = 8'h30 + 8'(j);
            check("drain_data", 32'(data), 32'(v));
            pop();
        end
        check("drain_last", 32'(data), 32'hC3);
        pop();
        check("drain_count", 32'(count), 32'd0);

        // Reset three data bits into 0x55 with an entry already held.
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        repeat (40) @(negedge clk);
        check("midrst_nopush", 32'(RXRDY), 32'd0);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("post_rst_count", 32'(count), 32'd1);
        check_head("post_rst", 8'h12, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
